// File: rtl/ct_l2cache_dirty_ctrl.sv
// ct_l2cache_dirty_ctrl
// Access controller for the L2 dirty-array single-port SRAM. After reset it
// clears every entry, then serves read / masked-write / swap requests with at
// most one SRAM access per cycle. Read data comes back two cycles after
// acceptance, with no backpressure.
module ct_l2cache_dirty_ctrl #(
   parameter int TAG_INDEX_WIDTH = 9,
   parameter int DATA_WIDTH      = 144
) (
   input  logic                       dirty_clk,
   input  logic                       dirty_rst,
   input  logic                       req_vld,
   output logic                       req_rdy,
   input  logic [1:0]                 req_op,
   input  logic [TAG_INDEX_WIDTH-1:0] req_idx,
   input  logic [DATA_WIDTH-1:0]      req_din,
   input  logic [DATA_WIDTH-1:0]      req_bwe,
   output logic                       rsp_vld,
   output logic [DATA_WIDTH-1:0]      rsp_data,
   output logic                       init_done,
   output logic                       dirty_cen,
   output logic                       dirty_gwen,
   output logic [TAG_INDEX_WIDTH-1:0] dirty_idx,
   output logic [DATA_WIDTH-1:0]      dirty_din,
   output logic [DATA_WIDTH-1:0]      dirty_wen,
   input  logic [DATA_WIDTH-1:0]      dirty_dout
);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_SWPW = 2'd2;   // second (write) cycle of a swap

   // Counter carries one extra bit: reaching 2^W means every entry was issued.
   localparam logic [TAG_INDEX_WIDTH:0] CNT_END = {1'b1, {TAG_INDEX_WIDTH{1'b0}}};
   localparam logic [TAG_INDEX_WIDTH:0] CNT_ONE = {{TAG_INDEX_WIDTH{1'b0}}, 1'b1};

   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_SWAP = 2'b10;

   logic [1:0]                 state_q,     state_d;
   logic [TAG_INDEX_WIDTH:0]   cnt_q,       cnt_d;
   logic                       cen_q,       cen_d;
   logic                       gwen_q,      gwen_d;
   logic [TAG_INDEX_WIDTH-1:0] idx_q,       idx_d;
   logic [DATA_WIDTH-1:0]      din_q,       din_d;
   logic [DATA_WIDTH-1:0]      wen_q,       wen_d;
   logic                       rd_pend_q,   rd_pend_d;
   logic                       rsp_vld_q,   rsp_vld_d;
   logic                       init_done_q, init_done_d;
   logic [TAG_INDEX_WIDTH-1:0] sw_idx_q,    sw_idx_d;
   logic [DATA_WIDTH-1:0]      sw_din_q,    sw_din_d;
   logic [DATA_WIDTH-1:0]      sw_bwe_q,    sw_bwe_d;

   // Only the swap write cycle and INIT block new requests.
   assign req_rdy    = (state_q == ST_RUN);
   assign rsp_vld    = rsp_vld_q;
   assign rsp_data   = rsp_vld_q ? dirty_dout : '0;
   assign init_done  = init_done_q;
   assign dirty_cen  = cen_q;
   assign dirty_gwen = gwen_q;
   assign dirty_idx  = idx_q;
   assign dirty_din  = din_q;
   assign dirty_wen  = wen_q;

   // Next-state and next SRAM command; idle cycles hold idx/din to avoid toggling.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cen_d       = 1'b1;
      gwen_d      = 1'b1;
      idx_d       = idx_q;
      din_d       = din_q;
      wen_d       = '1;
      rd_pend_d   = 1'b0;
      rsp_vld_d   = rd_pend_q;
      init_done_d = init_done_q;
      sw_idx_d    = sw_idx_q;
      sw_din_d    = sw_din_q;
      sw_bwe_d    = sw_bwe_q;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == CNT_END) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end else begin
               cen_d  = 1'b0;
               gwen_d = 1'b0;
               wen_d  = '0;
               din_d  = '0;
               idx_d  = cnt_q[TAG_INDEX_WIDTH-1:0];
               cnt_d  = cnt_q + CNT_ONE;
            end
         end
         ST_RUN: begin
            if (req_vld) begin
               cen_d = 1'b0;
               idx_d = req_idx;
               if (req_op == OP_WR) begin
                  gwen_d = 1'b0;
                  din_d  = req_din;
                  wen_d  = ~req_bwe;
               end else if (req_op == OP_SWAP) begin
                  rd_pend_d = 1'b1;
                  sw_idx_d  = req_idx;
                  sw_din_d  = req_din;
                  sw_bwe_d  = req_bwe;
                  state_d   = ST_SWPW;
               end else begin
                  rd_pend_d = 1'b1;
               end
            end
         end
         ST_SWPW: begin
            cen_d   = 1'b0;
            gwen_d  = 1'b0;
            idx_d   = sw_idx_q;
            din_d   = sw_din_q;
            wen_d   = ~sw_bwe_q;
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // State and registered SRAM interface; reset drops any pending swap write.
   always_ff @(posedge dirty_clk) begin
      if (dirty_rst) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         cen_q       <= 1'b1;
         gwen_q      <= 1'b1;
         idx_q       <= '0;
         din_q       <= '0;
         wen_q       <= '1;
         rd_pend_q   <= 1'b0;
         rsp_vld_q   <= 1'b0;
         init_done_q <= 1'b0;
         sw_idx_q    <= '0;
         sw_din_q    <= '0;
         sw_bwe_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cen_q       <= cen_d;
         gwen_q      <= gwen_d;
         idx_q       <= idx_d;
         din_q       <= din_d;
         wen_q       <= wen_d;
         rd_pend_q   <= rd_pend_d;
         rsp_vld_q   <= rsp_vld_d;
         init_done_q <= init_done_d;
         sw_idx_q    <= sw_idx_d;
         sw_din_q    <= sw_din_d;
         sw_bwe_q    <= sw_bwe_d;
      end
   end

endmodule
